// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-interconnect arbiter: state encoding,
// default sizing and well-known requester indices.
package mem_bus_pkg;

  localparam int unsigned NREQ_DEF          = 4;
  localparam int unsigned GRANT_TIMEOUT_DEF = 8;
  localparam int unsigned CNT_W_DEF         = 4;

  localparam int unsigned REQ_ICACHE = 0;
  localparam int unsigned REQ_DCACHE = 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_TURN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping mod NREQ.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % NREQ);
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbiter for the shared tristate memory bus, with a
// turnaround cycle between owners and revocation of unclaimed grants.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter  int unsigned NREQ          = NREQ_DEF,
  parameter  int unsigned GRANT_TIMEOUT = GRANT_TIMEOUT_DEF,
  parameter  int unsigned CNT_W         = CNT_W_DEF,
  localparam int unsigned IW            = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            bus_busy_in,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   owner,
  output logic            owner_valid,
  output logic            bus_idle,
  output logic            grant_timeout,
  output logic            protocol_err
);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   rr_ptr, rr_d;
  logic [CNT_W-1:0] tcnt, tcnt_d;
  logic [NREQ-1:0] grant_d;
  logic [IW-1:0]   owner_d, winner, owner_next;
  logic            owner_valid_d, bus_idle_d, timeout_d, perr_d, any_req;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Pointer advances past the owner on every release so a dead requester cannot starve others.
  assign owner_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_ptr;
    tcnt_d        = tcnt;
    grant_d       = '0;
    owner_d       = owner;
    owner_valid_d = 1'b0;
    bus_idle_d    = 1'b0;
    timeout_d     = 1'b0;
    perr_d        = protocol_err;
    case (state_q)
      ARB_IDLE: begin
        bus_idle_d = 1'b1;
        if (bus_busy_in) begin
          perr_d = 1'b1;
        end else if (any_req) begin
          state_d       = ARB_GRANT;
          grant_d       = NREQ'(1) << winner;
          owner_d       = winner;
          owner_valid_d = 1'b1;
          bus_idle_d    = 1'b0;
          tcnt_d        = '0;
        end
      end
      ARB_GRANT: begin
        if (bus_busy_in) begin
          state_d       = ARB_BUSY;
          owner_valid_d = 1'b1;
        end else if (!req[owner]) begin
          state_d = ARB_TURN;
          rr_d    = owner_next;
        end else if (tcnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
          state_d   = ARB_TURN;
          rr_d      = owner_next;
          timeout_d = 1'b1;
        end else begin
          grant_d       = grant;
          owner_valid_d = 1'b1;
          tcnt_d        = tcnt + CNT_W'(1);
        end
      end
      ARB_BUSY: begin
        if (bus_busy_in) begin
          owner_valid_d = 1'b1;
        end else begin
          state_d = ARB_TURN;
          rr_d    = owner_next;
        end
      end
      ARB_TURN: begin
        state_d    = ARB_IDLE;
        bus_idle_d = 1'b1;
      end
      default: begin
        state_d    = ARB_IDLE;
        bus_idle_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      rr_ptr        <= '0;
      tcnt          <= '0;
      grant         <= '0;
      owner         <= IW'(REQ_ICACHE);
      owner_valid   <= 1'b0;
      bus_idle      <= 1'b1;
      grant_timeout <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr        <= rr_d;
      tcnt          <= tcnt_d;
      grant         <= grant_d;
      owner         <= owner_d;
      owner_valid   <= owner_valid_d;
      bus_idle      <= bus_idle_d;
      grant_timeout <= timeout_d;
      protocol_err  <= perr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized
// requester behaviour, all checked against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_BUSY  = 2;
  localparam int P_TURN  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       bus_busy_in;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       owner_valid, bus_idle, grant_timeout, protocol_err;

  int checks = 0;
  int errors = 0;

  int m_ph, m_owner, m_age, m_ptr;
  bit m_pulse, m_perr;

  mem_bus_arbiter #(.NREQ(4), .GRANT_TIMEOUT(8), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .bus_busy_in   (bus_busy_in),
    .grant         (grant),
    .owner         (owner),
    .owner_valid   (owner_valid),
    .bus_idle      (bus_idle),
    .grant_timeout (grant_timeout),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic m_reset();
    m_ph = P_IDLE; m_owner = 0; m_age = 0; m_ptr = 0; m_pulse = 0; m_perr = 0;
  endtask

  // One clock of the arbitration rules at transaction level.
  task automatic m_step(input logic [3:0] r, input logic b);
    m_pulse = 0;
    case (m_ph)
      P_IDLE:
        if (b) m_perr = 1;
        else if (r != 4'h0) begin
          m_owner = pick(r, m_ptr); m_age = 0; m_ph = P_GRANT;
        end
      P_GRANT:
        if (b) m_ph = P_BUSY;
        else if (!r[m_owner]) begin
          m_ph = P_TURN; m_ptr = (m_owner + 1) % NREQ;
        end else if (m_age == TO - 1) begin
          m_ph = P_TURN; m_ptr = (m_owner + 1) % NREQ; m_pulse = 1;
        end else m_age++;
      P_BUSY:
        if (!b) begin
          m_ph = P_TURN; m_ptr = (m_owner + 1) % NREQ;
        end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_ph == P_GRANT) ? (4'b0001 << m_owner) : 4'b0000;
    check("grant", 32'(grant), 32'(eg));
    check("owner", 32'(owner), 32'(m_owner));
    check("owner_valid", 32'(owner_valid), 32'(m_ph == P_GRANT || m_ph == P_BUSY));
    check("bus_idle", 32'(bus_idle), 32'(m_ph == P_IDLE));
    check("grant_timeout", 32'(grant_timeout), 32'(m_pulse));
    check("protocol_err", 32'(protocol_err), 32'(m_perr));
  endtask

  task automatic step(input logic [3:0] r, input logic b);
    req = r;
    bus_busy_in = b;
    @(posedge clk);
    m_step(r, b);
    #1 check_outputs();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs();
    #3 reset = 1'b1;
  endtask

  initial begin
    int gcnt, pcnt, claim_pct;
    logic [3:0] r;
    logic b;

    // Reset with all requests up
    reset = 1'b0; req = 4'hF; bus_busy_in = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_bus_idle", 32'(bus_idle), 32'h1);
    check("rst_perr", 32'(protocol_err), 32'h0);
    check_outputs();
    #3 reset = 1'b1;
    step(4'hF, 1'b0);
    check("first_grant", 32'(grant), 32'h1);

    // Round-robin with 3-cycle ownerships
    for (int o = 0; o < 5; o++) begin
      check("rr_owner", 32'(owner), 32'(o % 4));
      check("rr_grant", 32'(grant), 32'(4'b0001 << (o % 4)));
      repeat (3) step(4'hF, 1'b1);
      step(4'hF, 1'b0);
      check("turn_idle", 32'(bus_idle), 32'h0);
      check("turn_ov", 32'(owner_valid), 32'h0);
      step(4'hF, 1'b0);
      step(4'hF, 1'b0);
    end
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);

    // Unclaimed grant to requester 2
    gcnt = 0; pcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b0100, 1'b0);
      if (grant[2]) gcnt++;
      if (grant_timeout) pcnt++;
    end
    check("timeout_grant_cycles", 32'(gcnt), 32'd8);
    check("timeout_pulses", 32'(pcnt), 32'd1);
    step(4'hF, 1'b0);
    check("rr_after_timeout", 32'(owner), 32'd3);

    // Busy wins over abandon on the same cycle
    step(4'h7, 1'b1);
    check("busy_over_abandon_ov", 32'(owner_valid), 32'h1);
    check("busy_over_abandon_to", 32'(grant_timeout), 32'h0);
    step(4'h7, 1'b0);
    step(4'h0, 1'b0);

    // Bus driven while idle
    repeat (3) step(4'b0010, 1'b1);
    check("perr_set", 32'(protocol_err), 32'h1);
    check("perr_no_grant", 32'(grant), 32'h0);
    step(4'b0010, 1'b0);
    check("perr_then_grant", 32'(grant), 32'h2);
    check("perr_sticky", 32'(protocol_err), 32'h1);

    // Asynchronous reset while busy
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_ov", 32'(owner_valid), 32'h0);
    check("async_grant", 32'(grant), 32'h0);
    check("async_perr", 32'(protocol_err), 32'h0);
    m_reset();
    #2 reset = 1'b1;
    step(4'hF, 1'b0);
    check("rearb_owner", 32'(owner), 32'h0);

    // Randomized requesters
    r = 4'hF;
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0: claim_pct = 90;
        1: claim_pct = 50;
        2: claim_pct = 10;
        default: claim_pct = 70;
      endcase
      do_reset();
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < NREQ; k++)
          if ($urandom_range(7) == 0) r[k] = ~r[k];
        case (m_ph)
          P_GRANT: begin
            b = ($urandom_range(99) < claim_pct);
            if ($urandom_range(15) == 0) r[m_owner] = 1'b0;
          end
          P_BUSY:  b = ($urandom_range(3) != 0);
          P_IDLE:  b = ($urandom_range(49) == 0);
          default: b = 1'b0;
        endcase
        step(r, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
